// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 19-bit CPU: fetch, IR load, decode, memory
// access, ALU execute and PC update, with a mem_ready timeout on every bus cycle.
module cpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int OPW     = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_zero_flag,
  input  logic           i_mem_ready,
  output logic           o_mem_rd,
  output logic           o_mem_wr,
  output logic           o_addr_sel_pc,
  output logic           o_load_ir,
  output logic           o_pc_inc,
  output logic           o_pc_load,
  output logic           o_acc_load,
  output logic           o_acc_src,
  output logic [2:0]     o_alu_op,
  output logic           o_halted,
  output logic           o_illegal_op,
  output logic           o_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [OPW-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPW-1:0] OP_LOAD  = 5'b00001;
  localparam logic [OPW-1:0] OP_STORE = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD   = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB   = 5'b00100;
  localparam logic [OPW-1:0] OP_AND   = 5'b00101;
  localparam logic [OPW-1:0] OP_OR    = 5'b00110;
  localparam logic [OPW-1:0] OP_XOR   = 5'b00111;
  localparam logic [OPW-1:0] OP_JMP   = 5'b01000;
  localparam logic [OPW-1:0] OP_JZ    = 5'b01001;
  localparam logic [OPW-1:0] OP_HLT   = 5'b11111;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_LOAD_IR = 4'd2,
    ST_IR_WAIT = 4'd3,
    ST_DECODE  = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_EXEC    = 4'd6,
    ST_MEM_WR  = 4'd7,
    ST_JUMP    = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait_cnt;
  logic [2:0]    r_alu_op;
  logic [2:0]    w_alu_op_nxt;
  logic          r_exec_alu;
  logic          w_exec_alu_nxt;
  logic          r_illegal;
  logic          r_bus_err;
  logic          w_set_ill;
  logic          w_set_berr;
  logic          w_in_bus;
  logic          w_timeout;

  assign w_in_bus  = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_timeout = (r_wait_cnt == TMAX);

  // State, ALU-op, operand-source and sticky error registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_alu_op   <= 3'd0;
      r_exec_alu <= 1'b0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_alu_op   <= w_alu_op_nxt;
      r_exec_alu <= w_exec_alu_nxt;
      r_illegal  <= r_illegal | w_set_ill;
      r_bus_err  <= r_bus_err | w_set_berr;
    end
  end

  // Wait counter: zero on entry to a bus state, counts each held cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt <= {CW{1'b0}};
    end else if ((w_next != r_state) || !w_in_bus) begin
      r_wait_cnt <= {CW{1'b0}};
    end else begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  // Next-state logic, decode side effects and timeout detection.
  always_comb begin
    w_next         = r_state;
    w_alu_op_nxt   = r_alu_op;
    w_exec_alu_nxt = r_exec_alu;
    w_set_ill      = 1'b0;
    w_set_berr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
        if (i_mem_ready) begin
          if (r_state == ST_FETCH) begin
            w_next = ST_LOAD_IR;
          end else if (r_state == ST_MEM_RD) begin
            w_next = ST_EXEC;
          end else begin
            w_next = ST_FETCH;
          end
        end else if (w_timeout) begin
          w_next     = ST_HALT;
          w_set_berr = 1'b1;
        end else begin
          w_next = r_state;
        end
      end
      ST_LOAD_IR: w_next = ST_IR_WAIT;
      // IR_WAIT covers the second IR register stage; opcode is valid in DECODE.
      ST_IR_WAIT: w_next = ST_DECODE;
      ST_DECODE: begin
        case (i_opcode)
          OP_NOP:   w_next = ST_FETCH;
          OP_LOAD: begin
            w_next         = ST_MEM_RD;
            w_exec_alu_nxt = 1'b0;
          end
          OP_STORE: w_next = ST_MEM_WR;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            w_next         = ST_MEM_RD;
            w_exec_alu_nxt = 1'b1;
            case (i_opcode)
              OP_ADD:  w_alu_op_nxt = 3'd0;
              OP_SUB:  w_alu_op_nxt = 3'd1;
              OP_AND:  w_alu_op_nxt = 3'd2;
              OP_OR:   w_alu_op_nxt = 3'd3;
              default: w_alu_op_nxt = 3'd4;
            endcase
          end
          OP_JMP:   w_next = ST_JUMP;
          OP_JZ: begin
            if (i_zero_flag) begin
              w_next = ST_JUMP;
            end else begin
              w_next = ST_FETCH;
            end
          end
          OP_HLT:   w_next = ST_HALT;
          default: begin
            w_next    = ST_HALT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      ST_EXEC:  w_next = ST_FETCH;
      ST_JUMP:  w_next = ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_addr_sel_pc = 1'b0;
    o_load_ir     = 1'b0;
    o_pc_inc      = 1'b0;
    o_pc_load     = 1'b0;
    o_acc_load    = 1'b0;
    o_acc_src     = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_mem_rd      = 1'b1;
        o_addr_sel_pc = 1'b1;
      end
      ST_LOAD_IR: begin
        o_load_ir = 1'b1;
        o_pc_inc  = 1'b1;
      end
      ST_MEM_RD: o_mem_rd = 1'b1;
      ST_EXEC: begin
        o_acc_load = 1'b1;
        o_acc_src  = r_exec_alu;
      end
      ST_MEM_WR: o_mem_wr  = 1'b1;
      ST_JUMP:   o_pc_load = 1'b1;
      ST_HALT:   o_halted  = 1'b1;
      default:   o_halted  = 1'b0;
    endcase
  end

  assign o_alu_op     = r_alu_op;
  assign o_illegal_op = r_illegal;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: per-cycle expected output vectors are queued
// with the stimulus and compared on the falling edge.
module tb_cpu_ctrl_fsm;

  localparam int TIMEOUT = 15;

  // Strobe groups: {mem_rd, mem_wr, addr_sel_pc, load_ir, pc_inc, pc_load, acc_load, acc_src}
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_FETCH = 8'b1010_0000;
  localparam logic [7:0] S_LDIR  = 8'b0001_1000;
  localparam logic [7:0] S_MRD   = 8'b1000_0000;
  localparam logic [7:0] S_MWR   = 8'b0100_0000;
  localparam logic [7:0] S_JMP   = 8'b0000_0100;
  localparam logic [7:0] S_EXL   = 8'b0000_0010;
  localparam logic [7:0] S_EXA   = 8'b0000_0011;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] opcode;
  logic       zero_flag;
  logic       mem_ready;
  logic       mem_rd, mem_wr, addr_sel_pc, load_ir, pc_inc, pc_load, acc_load, acc_src;
  logic [2:0] alu_op;
  logic       halted, illegal_op, bus_err;
  logic [13:0] obs_vec;

  typedef struct {
    string      tag;
    logic [13:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  logic [2:0]  e_alu;
  logic        e_ill;
  logic        e_berr;
  int          n_checks;
  int          n_errors;

  cpu_ctrl_fsm #(.TIMEOUT(TIMEOUT), .OPW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_opcode(opcode),
    .i_zero_flag(zero_flag), .i_mem_ready(mem_ready),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_addr_sel_pc(addr_sel_pc),
    .o_load_ir(load_ir), .o_pc_inc(pc_inc), .o_pc_load(pc_load),
    .o_acc_load(acc_load), .o_acc_src(acc_src), .o_alu_op(alu_op),
    .o_halted(halted), .o_illegal_op(illegal_op), .o_bus_err(bus_err)
  );

  assign obs_vec = {mem_rd, mem_wr, addr_sel_pc, load_ir, pc_inc, pc_load, acc_load, acc_src,
                    alu_op, halted, illegal_op, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e_cur = exp_q.pop_front();
      check_eq(e_cur.tag, {18'd0, obs_vec}, {18'd0, e_cur.v});
    end
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive mem_ready for the coming edge and queue the outputs expected after it.
  task automatic cyc(input string tag, input logic rdy, input logic [7:0] s, input logic h);
    exp_t x;
    mem_ready = rdy;
    x.tag = tag;
    x.v   = {s, e_alu, h, e_ill, e_berr};
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    e_alu  = 3'd0;
    e_ill  = 1'b0;
    e_berr = 1'b0;
    for (int i = 0; i < n; i++) cyc("reset", rnd(), S_NONE, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc("start", rnd(), S_FETCH, 1'b0);
    start = 1'b0;
  endtask

  // Entered with the DUT in FETCH; leaves it in DECODE.
  task automatic do_fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, S_FETCH, 1'b0);
    cyc("fetch_done", 1'b1, S_LDIR, 1'b0);
    cyc("ir_wait", rnd(), S_NONE, 1'b0);
    cyc("decode", rnd(), S_NONE, 1'b0);
  endtask

  task automatic data_rd(input int waits, input logic [7:0] ex);
    for (int i = 0; i < waits; i++) cyc("memrd_wait", 1'b0, S_MRD, 1'b0);
    cyc("exec", 1'b1, ex, 1'b0);
    cyc("exec_to_fetch", rnd(), S_FETCH, 1'b0);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic zf, input int fw, input int dw);
    opcode    = op;
    zero_flag = zf;
    do_fetch(fw);
    case (op)
      5'b00000: cyc("nop_fetch", rnd(), S_FETCH, 1'b0);
      5'b00001: begin
        cyc("load_memrd", rnd(), S_MRD, 1'b0);
        data_rd(dw, S_EXL);
      end
      5'b00010: begin
        cyc("store_memwr", rnd(), S_MWR, 1'b0);
        for (int i = 0; i < dw; i++) cyc("memwr_wait", 1'b0, S_MWR, 1'b0);
        cyc("store_done", 1'b1, S_FETCH, 1'b0);
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111: begin
        e_alu = 3'(op - 5'd3);
        cyc("alu_memrd", rnd(), S_MRD, 1'b0);
        data_rd(dw, S_EXA);
      end
      5'b01000: begin
        cyc("jmp", rnd(), S_JMP, 1'b0);
        cyc("jmp_fetch", rnd(), S_FETCH, 1'b0);
      end
      5'b01001: begin
        if (zf) begin
          cyc("jz_taken", rnd(), S_JMP, 1'b0);
          cyc("jz_fetch", rnd(), S_FETCH, 1'b0);
        end else begin
          cyc("jz_not_taken", rnd(), S_FETCH, 1'b0);
        end
      end
      5'b11111: cyc("hlt", rnd(), S_NONE, 1'b1);
      default: begin
        e_ill = 1'b1;
        cyc("illegal", rnd(), S_NONE, 1'b1);
      end
    endcase
  endtask

  // Current bus state held with mem_ready low until the timeout edge.
  task automatic bus_timeout(input logic [7:0] s);
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i < TIMEOUT) begin
        cyc("bus_hold", 1'b0, s, 1'b0);
      end else begin
        e_berr = 1'b1;
        cyc("bus_timeout", 1'b0, S_NONE, 1'b1);
      end
    end
  endtask

  task automatic hold_halt(input int n);
    start = 1'b1;
    for (int i = 0; i < n; i++) cyc("halt_hold", rnd(), S_NONE, 1'b1);
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = 5'd0;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    e_alu     = 3'd0;
    e_ill     = 1'b0;
    e_berr    = 1'b0;

    do_reset(3);
    for (int i = 0; i < 10; i++) cyc("idle", rnd(), S_NONE, 1'b0);
    do_start();
    for (int i = 0; i < 3; i++) run_instr(5'b00000, 1'b0, 0, 0);
    run_instr(5'b00100, 1'b0, 0, 0);
    run_instr(5'b00011, 1'b0, 0, 2);
    run_instr(5'b00101, 1'b1, 0, 0);
    run_instr(5'b00110, 1'b0, 1, 0);
    run_instr(5'b00111, 1'b0, 0, 1);
    run_instr(5'b00001, 1'b0, 0, 0);
    run_instr(5'b00010, 1'b0, 0, 1);
    run_instr(5'b01000, 1'b0, 0, 0);
    run_instr(5'b01001, 1'b0, 0, 0);
    run_instr(5'b01001, 1'b1, 0, 0);
    run_instr(5'b00000, 1'b0, TIMEOUT - 1, 0);
    run_instr(5'b00001, 1'b0, 0, TIMEOUT - 1);

    opcode = 5'b00010;
    do_fetch(0);
    cyc("store_memwr", rnd(), S_MWR, 1'b0);
    cyc("memwr_wait", 1'b0, S_MWR, 1'b0);
    do_reset(1);
    cyc("idle_after_rst", rnd(), S_NONE, 1'b0);
    do_start();

    run_instr(5'b10101, 1'b0, 0, 0);
    hold_halt(4);
    do_reset(1);
    do_start();

    bus_timeout(S_FETCH);
    hold_halt(4);
    do_reset(1);
    do_start();

    opcode = 5'b00001;
    do_fetch(0);
    cyc("load_memrd", rnd(), S_MRD, 1'b0);
    bus_timeout(S_MRD);
    hold_halt(3);
    do_reset(2);
    do_start();

    run_instr(5'b00011, 1'b0, 0, 0);
    run_instr(5'b11111, 1'b0, 0, 0);
    hold_halt(3);

    @(negedge clk);
    #1;
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit for the 19-bit CPU. It sequences fetch, IR load, decode, memory access, ALU execute and PC update, driving the instruction register's load strobe. It consumes the registered 5-bit opcode and respects that register's two-edge capture-to-output latency. It sits between the instruction register, PC, accumulator/ALU and the memory bus. A memory-ready handshake with timeout guards every bus cycle.

Parameters:
TIMEOUT, 15, maximum cycles a bus state waits for mem_ready (inclusive); range 1..255
OPW, 5, opcode width; fixed at 5 for this ISA

Ports:
clk  input  1  system clock, all state changes on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  level; leaves IDLE when 1
opcode  input  OPW  opcode from instruction register output
zero_flag  input  1  accumulator == 0, from datapath
mem_ready  input  1  memory completes current read/write this cycle
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request (accumulator drives data)
addr_sel_pc  output  1  1 = bus address from PC, 0 = IR address field
load_ir  output  1  instruction register load strobe
pc_inc  output  1  PC <= PC+1 (14-bit wrap 0x3FFF -> 0x0000, handled in PC)
pc_load  output  1  PC <= IR address
acc_load  output  1  accumulator write enable
acc_src  output  1  0 = memory data, 1 = ALU result
alu_op  output  3  registered ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
halted  output  1  in HALT state
illegal_op  output  1  sticky; undefined opcode decoded
bus_err  output  1  sticky; mem_ready timeout

Behaviour:
- Opcodes: 00000 NOP, 00001 LOAD, 00010 STORE, 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 XOR, 01000 JMP, 01001 JZ, 11111 HLT. All others are illegal.
- States: IDLE, FETCH, LOAD_IR, IR_WAIT, DECODE, MEM_RD, EXEC, MEM_WR, JUMP, HALT. Outputs are Moore, decoded from the state register only; alu_op is a register.
- Reset (rst_n=0 at a posedge): state=IDLE, alu_op=0, illegal_op=0, bus_err=0, wait counter=0. All strobes are 0 in IDLE. Reset overrides any in-progress state, including mid-bus-cycle.
- IDLE: start=1 -> FETCH; otherwise hold.
- FETCH: mem_rd=1, addr_sel_pc=1. mem_ready=1 -> LOAD_IR.
- LOAD_IR: load_ir=1, pc_inc=1 for exactly one cycle -> IR_WAIT.
- IR_WAIT: no strobes. This absorbs the IR's second register stage -> DECODE.
- DECODE: samples opcode, whose register output is valid this cycle. Captures alu_op for ADD..XOR (ADD=0 .. XOR=4); LOAD leaves alu_op unchanged. Transitions:
  - NOP -> FETCH
  - LOAD, ADD..XOR -> MEM_RD
  - STORE -> MEM_WR
  - JMP -> JUMP
  - JZ -> JUMP if zero_flag=1, else FETCH
  - HLT -> HALT
  - illegal -> set illegal_op, then HALT
- MEM_RD: mem_rd=1, addr_sel_pc=0. mem_ready=1 -> EXEC.
- EXEC: acc_load=1. acc_src=0 for LOAD, 1 for ALU ops -> FETCH.
- MEM_WR: mem_wr=1, addr_sel_pc=0. mem_ready=1 -> FETCH.
- JUMP: pc_load=1 -> FETCH.
- HALT: halted=1 and all strobes 0. Holds until reset; start is ignored.
- mem_rd and mem_wr are never both 1. load_ir, pc_inc, pc_load and acc_load each last exactly one cycle per instruction.
- Wait counter, ceil(log2(TIMEOUT+1)) bits:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR; increments each cycle the state is held with mem_ready=0.
  - mem_ready=1 in cycle k of the state (k = 1..TIMEOUT) is accepted.
  - If the TIMEOUT-th cycle ends with mem_ready=0: set bus_err, then HALT. The strobe drops on that edge.
- mem_ready outside a bus state is ignored.
- Latency with zero wait states:
  - NOP / JZ not taken: 4 cycles
  - JMP / JZ taken: 5
  - STORE: 5
  - LOAD / ALU: 6
  - Each wait state adds 1.

Test Plan:
- Reset held 3 cycles then released, start=0 -> IDLE; every output 0; remains 0 for 10 cycles.
- start=1, mem_ready=1 always, opcode=00000 -> load_ir pulses every 4 cycles; pc_inc coincident with load_ir; no other strobes.
- opcode=00011 (ADD), mem_ready low 2 cycles in MEM_RD -> alu_op=0; mem_rd high 3 cycles with addr_sel_pc=0; then acc_load=1 with acc_src=1; 8 cycles total.
- opcode=01001 with zero_flag=0, then zero_flag=1 -> first: no pc_load, next FETCH after 4 cycles; second: pc_load pulse in cycle 5.
- TIMEOUT=15, mem_ready=0 in FETCH -> mem_rd high exactly 15 cycles; bus_err=1 and halted=1 next; start ignored. Variant: mem_ready asserted in cycle 15 -> accepted, no bus_err.
- opcode=10101 -> illegal_op=1, halted=1 after DECODE. Separately, rst_n=0 asserted during MEM_WR -> mem_wr=0 and state IDLE after that edge; sticky flags cleared.
